// File: rtl/arb_pkg.sv
// ---------------------------------------------------------------------------
// arb_pkg
// Shared types and helpers for the round-robin port arbiter.
//   NREQ        : number of requesters contending for the shared port
//   arb_state_t : arbiter FSM state (IDLE between owners, OWN while granted)
//   onehot4()   : 2-bit index -> one-hot 4-bit grant vector
// ---------------------------------------------------------------------------
package arb_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_OWN
  } arb_state_t;

  function automatic logic [NREQ-1:0] onehot4(input logic [1:0] idx);
    logic [NREQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/mux4.sv
// ---------------------------------------------------------------------------
// mux4
// Single-bit 4:1 multiplexer, the leaf cell of the shared-port mux tree.
//   i_d   [3:0] : data inputs, i_d[n] is selected when i_sel == n
//   i_sel [1:0] : select
//   o_y         : selected bit
// ---------------------------------------------------------------------------
module mux4 (
  input  logic [3:0] i_d,
  input  logic [1:0] i_sel,
  output logic       o_y
);

  assign o_y = i_d[i_sel];

endmodule

// File: rtl/rr_pick4.sv
// ---------------------------------------------------------------------------
// rr_pick4
// Combinational round-robin picker. Scans requests starting one past the
// last owner (i_ptr+1, i_ptr+2, ... wrapping 3->0) and returns the first
// asserted index.
//   i_req [3:0] : request vector
//   i_ptr [1:0] : index of the last owner (lowest priority this round)
//   o_any       : at least one request is asserted
//   o_idx [1:0] : chosen requester (don't-care when o_any is low)
// ---------------------------------------------------------------------------
module rr_pick4
  import arb_pkg::*;
(
  input  logic [NREQ-1:0] i_req,
  input  logic [1:0]      i_ptr,
  output logic            o_any,
  output logic [1:0]      o_idx
);

  logic [1:0]      w_base;
  logic [NREQ-1:0] w_rot;
  logic [1:0]      w_off;

  assign w_base = i_ptr + 2'd1;

  // Rotate so that w_rot[0] is the highest-priority requester; the 2-bit
  // index arithmetic provides the mod-4 wrap for free.
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
      localparam logic [1:0] OFS = 2'(gi);
      assign w_rot[gi] = i_req[w_base + OFS];
    end
  endgenerate

  // Priority-encode lowest set bit of the rotated vector.
  always_comb begin
    w_off = 2'd0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (w_rot[k]) w_off = 2'(k);
    end
  end

  // Unrotate back to an absolute requester index.
  assign o_idx = w_base + w_off;
  assign o_any = |i_req;

endmodule

// File: rtl/rr_port_arbiter.sv
// ---------------------------------------------------------------------------
// rr_port_arbiter
// Round-robin arbiter and select controller for a shared 4-input datapath
// port. Grants one owner at a time, bounds each burst to MAX_BURST cycles
// when someone else is waiting, and drives the select of the bitwise 4:1
// mux tree that builds out_data.
//   clk       : clock
//   reset     : synchronous active-high reset
//   req  [3:0]: per-requester request, held for the whole transaction
//   din       : requester data, din[i*WIDTH +: WIDTH] is requester i
//   gnt  [3:0]: registered one-hot grant (or 0)
//   sel  [1:0]: registered mux select, index of current/last owner
//   out_valid : the owner still requests and holds the grant this cycle
//   out_data  : din slice selected by sel
//   busy      : FSM is in the OWN state
// ---------------------------------------------------------------------------
module rr_port_arbiter
  import arb_pkg::*;
#(
  parameter int WIDTH     = 64,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] din,
  output logic [NREQ-1:0]       gnt,
  output logic [1:0]            sel,
  output logic                  out_valid,
  output logic [WIDTH-1:0]      out_data,
  output logic                  busy
);

  localparam int             CW   = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0]  MAXC = CW'(MAX_BURST);

  arb_state_t       r_state;
  logic [1:0]       r_ptr;
  logic [CW-1:0]    r_cnt;
  logic [NREQ-1:0]  r_gnt;
  logic [1:0]       r_sel;

  logic             w_any;
  logic [1:0]       w_pick;
  logic             w_owner_req;
  logic             w_others_pending;

  rr_pick4 u_pick (
    .i_req (req),
    .i_ptr (r_ptr),
    .o_any (w_any),
    .o_idx (w_pick)
  );

  // In OWN, r_sel always names the owner, so it doubles as the owner index.
  assign w_owner_req      = req[r_sel];
  assign w_others_pending = |(req & ~onehot4(r_sel));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ARB_IDLE;
      r_gnt   <= '0;
      r_sel   <= 2'd0;
      r_ptr   <= 2'd3;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ARB_IDLE: begin
          if (w_any) begin
            r_gnt   <= onehot4(w_pick);
            r_sel   <= w_pick;
            r_cnt   <= CW'(1);
            r_state <= ARB_OWN;
          end else begin
            r_gnt   <= '0;
          end
        end
        ARB_OWN: begin
          // Release and preemption behave identically: the owner drops to
          // lowest priority and every hand-over passes through IDLE.
          if (!w_owner_req || (r_cnt == MAXC && w_others_pending)) begin
            r_gnt   <= '0;
            r_ptr   <= r_sel;
            r_state <= ARB_IDLE;
          end else if (r_cnt != MAXC) begin
            r_cnt   <= r_cnt + CW'(1);
          end
        end
        default: begin
          r_gnt   <= '0;
          r_state <= ARB_IDLE;
        end
      endcase
    end
  end

  assign gnt       = r_gnt;
  assign sel       = r_sel;
  assign busy      = (r_state == ARB_OWN);
  assign out_valid = |(r_gnt & req);

  // Bit-sliced 4:1 mux tree for the shared output.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_mux
      mux4 u_mux (
        .i_d   ({din[3*WIDTH + gi], din[2*WIDTH + gi], din[WIDTH + gi], din[gi]}),
        .i_sel (r_sel),
        .o_y   (out_data[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_rr_port_arbiter.sv
module tb_rr_port_arbiter;

  localparam int W = 64;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic [3:0]     req = 4'b0000;
  logic [4*W-1:0] din;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           busy;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] d_val [4];

  rr_port_arbiter #(.WIDTH(W), .MAX_BURST(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .din       (din),
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .out_data  (out_data),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req   = 4'b0000;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    d_val[0] = 64'hA5;
    d_val[1] = 64'h1111_2222_3333_4444;
    d_val[2] = 64'hC0DE_0000_0000_0002;
    d_val[3] = 64'hFFFF_0000_DEAD_BEEF;
    din = {d_val[3], d_val[2], d_val[1], d_val[0]};

    // 1: reset for 2 cycles with no requests
    do_reset();
    check_eq("rst_gnt", 64'(gnt), 64'h0);
    check_eq("rst_sel", 64'(sel), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_valid", 64'(out_valid), 64'h0);
    $display("txn reset: gnt=%b sel=%0d busy=%0b", gnt, sel, busy);

    // 2: single requester 0, one-cycle arbitration latency
    req = 4'b0001;
    tick();
    check_eq("t2_gnt", 64'(gnt), 64'h1);
    check_eq("t2_sel", 64'(sel), 64'h0);
    check_eq("t2_data", 64'(out_data), 64'hA5);
    check_eq("t2_valid", 64'(out_valid), 64'h1);
    check_eq("t2_busy", 64'(busy), 64'h1);
    req = 4'b0000;
    tick();
    check_eq("t2_rel_gnt", 64'(gnt), 64'h0);
    $display("txn single: owner 0 granted and released");

    // 3: all request, each owner holds 3 cycles then drops
    do_reset();
    begin
      int order [5] = '{0, 1, 2, 3, 0};
      logic [3:0] oh;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
        oh = 4'b0000;
        oh[order[t]] = 1'b1;
        for (int c = 0; c < 3; c++) begin
          tick();
          check_eq($sformatf("t3_g%0d_c%0d", t, c), 64'(gnt), 64'(oh));
        end
        check_eq($sformatf("t3_sel%0d", t), 64'(sel), 64'(order[t]));
        check_eq($sformatf("t3_data%0d", t), 64'(out_data), 64'(d_val[order[t]]));
        req = 4'b1111 & ~oh;
        tick();
        check_eq($sformatf("t3_idle%0d", t), 64'(gnt), 64'h0);
        check_eq($sformatf("t3_ivld%0d", t), 64'(out_valid), 64'h0);
        req = 4'b1111;
        $display("txn rr: owner %0d held 3 cycles", order[t]);
      end
    end

    // 4: burst limit preempts owner 0 when requester 2 waits
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_eq($sformatf("t4_own_c%0d", k), 64'(gnt), 64'h1);
      if (k == 3) req = 4'b0101;
    end
    tick();
    check_eq("t4_preempt", 64'(gnt), 64'h0);
    tick();
    check_eq("t4_gnt2", 64'(gnt), 64'h4);
    check_eq("t4_sel2", 64'(sel), 64'h2);
    check_eq("t4_data2", 64'(out_data), 64'(d_val[2]));
    req = 4'b0001;
    tick();
    check_eq("t4_rel2", 64'(gnt), 64'h0);
    tick();
    check_eq("t4_back0", 64'(gnt), 64'h1);
    $display("txn burst: owner 0 preempted after 8, owner 2 served");

    // 5: lone requester is never preempted; counter saturates
    do_reset();
    req = 4'b0001;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check_eq($sformatf("t5_gnt_c%0d", k), 64'(gnt), 64'h1);
      check_eq($sformatf("t5_cnt_c%0d", k), 64'(dut.r_cnt), 64'((k < 8) ? k : 8));
    end
    req = 4'b0011;
    tick();
    check_eq("t5_preempt", 64'(gnt), 64'h0);
    tick();
    check_eq("t5_gnt1", 64'(gnt), 64'h2);
    check_eq("t5_sel1", 64'(sel), 64'h1);
    req = 4'b0000;
    tick();
    check_eq("t5_rel", 64'(gnt), 64'h0);
    $display("txn lone: 20 cycles held, cnt saturated at 8");

    // 6: reset mid-transaction
    do_reset();
    req = 4'b0100;
    tick();
    check_eq("t6_gnt2", 64'(gnt), 64'h4);
    reset = 1'b1;
    req   = 4'b1111;
    tick();
    check_eq("t6_rst_gnt", 64'(gnt), 64'h0);
    check_eq("t6_rst_busy", 64'(busy), 64'h0);
    check_eq("t6_rst_ptr", 64'(dut.r_ptr), 64'h3);
    reset = 1'b0;
    tick();
    check_eq("t6_first", 64'(gnt), 64'h1);
    $display("txn midreset: grant cleared, first grant after reset is 0");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
